// File: rtl/sram_reader_pkg.sv
// Shared frame-buffer geometry, pixel/address widths and the reader state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Also used by the frame-buffer writer so both ports agree on layout.
package sram_reader_pkg;

   // Source frame as stored in BRAM, one RGB444 word per pixel, row-major.
   localparam int SRC_W       = 320;
   localparam int SRC_H       = 240;
   localparam int FRAME_WORDS = SRC_W * SRC_H;   // 76800

   // Displayed active area after 2x upscale in both axes.
   localparam int DST_W = 2 * SRC_W;              // 640
   localparam int DST_H = 2 * SRC_H;              // 480

   localparam int PIX_W  = 12;
   localparam int ADDR_W = 17;

   typedef enum logic [1:0] {
      WAIT_FRAME,   // idle until the first vsync rising edge after reset
      VBLANK,       // counters cleared, waiting for the first active line
      LINE,         // issuing one read per DE cycle
      HBLANK        // between active lines
   } rd_state_t;

endpackage

// File: rtl/sram_reader_sync_delay.sv
// Fixed-depth shift register used to align timing/control bits with BRAM read data.
// Latency: DEPTH cycles. Backpressure: none, advances every clock.
// Ports: clk, rst (sync, active-high, loads RST_VAL), d (W bits in), q (W bits out).
module sync_delay #(
   parameter int             DEPTH   = 3,
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_reader.sv
// Reads the SRC_W x SRC_H frame buffer and emits a 2x-upscaled pixel stream with delayed sync/DE.
// Latency: pix_* follow vid_* by exactly READ_LAT+2 cycles; pix_data is valid alongside pix_de.
// Backpressure: none; timing generator drives, BRAM must honour READ_LAT (1 or 2).
// Ports: clk/rst; vid_de/vid_hsync/vid_vsync from timing gen; bram_addr/bram_en/bram_rdata to
//        the BRAM read port; pix_data/pix_de/pix_hsync/pix_vsync to the encoder; frame_err sticky.
module sram_reader
   import sram_reader_pkg::*;
#(
   parameter int SRC_W    = sram_reader_pkg::SRC_W,
   parameter int SRC_H    = sram_reader_pkg::SRC_H,
   parameter int READ_LAT = 1,
   parameter int ADDR_W   = sram_reader_pkg::ADDR_W,
   parameter int PIX_W    = sram_reader_pkg::PIX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_de,
   input  logic              vid_hsync,
   input  logic              vid_vsync,
   input  logic [PIX_W-1:0]  bram_rdata,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_de,
   output logic              pix_hsync,
   output logic              pix_vsync,
   output logic              frame_err
);

   localparam int DEPTH  = READ_LAT + 2;
   localparam int COL_W  = $clog2(2 * SRC_W + 1);
   localparam int LINE_W = $clog2(2 * SRC_H + 1);
   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(2 * SRC_W);
   localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(2 * SRC_H);

   rd_state_t          state_q, state_d;
   logic               vs_prev_q;
   logic               vs_edge;
   logic [COL_W-1:0]   col_cnt_q;
   logic [LINE_W-1:0]  line_cnt_q;
   logic [ADDR_W-1:0]  row_base_q;
   logic [ADDR_W-1:0]  rd_addr;
   logic               line_active;
   logic               in_range;
   logic               rd_req;
   logic               overrun;
   logic               line_end;
   logic [PIX_W-1:0]   rdata_q;
   logic [3:0]         dly_q;
   logic               blank_d;

   assign vs_edge = vid_vsync & ~vs_prev_q;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_FRAME;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_FRAME: if (vs_edge) state_d = VBLANK;
         VBLANK:     if (vid_de)  state_d = LINE;
         LINE:       if (!vid_de) state_d = HBLANK;
         HBLANK:     if (vid_de)  state_d = LINE;
         default:    state_d = WAIT_FRAME;
      endcase
      // A vsync edge always restarts the frame; a truncated frame simply resynchronises.
      if (state_q != WAIT_FRAME && vs_edge) begin
         state_d = VBLANK;
      end
   end

   // ---------------------------------------------------------------- FSM decode
   // Any DE cycle outside WAIT_FRAME is treated as an active pixel, so the first DE cycle
   // after VBLANK/HBLANK already issues its read. The vsync edge has priority over DE.
   always_comb begin
      line_active = 1'b0;
      in_range    = 1'b0;
      rd_req      = 1'b0;
      overrun     = 1'b0;
      line_end    = 1'b0;
      rd_addr     = row_base_q + ADDR_W'(col_cnt_q >> 1);

      line_active = (state_q != WAIT_FRAME) && vid_de && !vs_edge;
      in_range    = (col_cnt_q < COL_MAX) && (line_cnt_q < LINE_MAX);
      rd_req      = line_active && in_range;
      overrun     = line_active && !in_range;
      line_end    = (state_q == LINE) && !vid_de && !vs_edge;
   end

   // ---------------------------------------------------------------- position counters
   // row_base steps by SRC_W after every odd destination line, giving (line>>1)*SRC_W
   // without a multiplier. It only advances for legal lines, so it tops out at FRAME_WORDS,
   // which is never issued because the line after that is already out of range.
   always_ff @(posedge clk) begin
      if (rst || vs_edge) begin
         col_cnt_q  <= '0;
         line_cnt_q <= '0;
         row_base_q <= '0;
      end else if (line_end) begin
         col_cnt_q <= '0;
         if (line_cnt_q < LINE_MAX) begin
            line_cnt_q <= line_cnt_q + LINE_W'(1);
            if (line_cnt_q[0]) begin
               row_base_q <= row_base_q + ADDR_W'(SRC_W);
            end
         end
      end else if (line_active && (col_cnt_q < COL_MAX)) begin
         col_cnt_q <= col_cnt_q + COL_W'(1);
      end
   end

   // ---------------------------------------------------------------- BRAM request / status
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev_q <= 1'b0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
         frame_err <= 1'b0;
         rdata_q   <= '0;
      end else begin
         vs_prev_q <= vid_vsync;
         bram_en   <= rd_req;
         if (rd_req) begin
            bram_addr <= rd_addr;
         end
         if (overrun) begin
            frame_err <= 1'b1;
         end
         rdata_q <= bram_rdata;
      end
   end

   // ---------------------------------------------------------------- alignment
   // {de, hsync, vsync, blank}; blank resets to 1 so stale BRAM data captured right
   // after reset can never reach pix_data.
   sync_delay #(
      .DEPTH   (DEPTH),
      .W       (4),
      .RST_VAL (4'b0001)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .d   ({vid_de, vid_hsync, vid_vsync, ~rd_req}),
      .q   (dly_q)
   );

   assign pix_de    = dly_q[3];
   assign pix_hsync = dly_q[2];
   assign pix_vsync = dly_q[1];
   assign blank_d   = dly_q[0];

   // Both operands are registers, so the encoder still sees a clean registered pixel.
   assign pix_data = blank_d ? '0 : rdata_q;

endmodule

// File: doc/sram_reader.md
Name: sram_reader

Overview:
- Display-side counterpart of the frame-buffer writer.
- Reads the 320x240 RGB444 frame buffer (76800 words, addresses 0..76799) in the 25 MHz pixel domain.
- Upscales 2x in both axes to a 640x480 active area and emits a pixel stream aligned with delayed sync/DE for the HDMI/VGA encoder.
- Sits between the video timing generator and the encoder; the writer owns the other BRAM port.

Parameters:
- SRC_W, 320, source frame width in pixels
- SRC_H, 240, source frame height in lines
- READ_LAT, 1, BRAM read latency in cycles (legal: 1 or 2)
- ADDR_W, 17, BRAM address width
- PIX_W, 12, pixel width (RGB444)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous active-high reset
- vid_de  in  1  active-video enable from timing generator
- vid_hsync  in  1  horizontal sync from timing generator, polarity passed through
- vid_vsync  in  1  vertical sync, active-high, same clock domain
- bram_rdata  in  PIX_W  BRAM read data, valid READ_LAT cycles after bram_en
- bram_addr  out  ADDR_W  BRAM read address
- bram_en  out  1  BRAM read enable
- pix_data  out  PIX_W  output pixel; 0 when not active
- pix_de  out  1  vid_de delayed
- pix_hsync  out  1  vid_hsync delayed
- pix_vsync  out  1  vid_vsync delayed
- frame_err  out  1  sticky flag: active line or pixel count exceeded 2*SRC_H or 2*SRC_W

Behaviour:
Reset:
- All outputs 0, all counters 0, delay lines cleared, state WAIT_FRAME.
- Reset asserted mid-frame aborts immediately.
- The block resumes only at the next vsync rising edge.

vsync edge:
- Detected when vid_vsync is 1 at the current sample and was 0 at the previous sample.

State machine:
- WAIT_FRAME:
  - bram_en=0.
  - Any vid_de is ignored; pix_data=0 while pix_de follows the delayed vid_de.
  - On vsync edge -> VBLANK.
- VBLANK:
  - Clear col_cnt, line_cnt, row_base.
  - On the first vid_de=1 -> LINE.
- LINE, per vid_de=1 cycle:
  - bram_addr = row_base + (col_cnt>>1), registered; bram_en=1; col_cnt++.
  - If col_cnt >= 2*SRC_W: bram_en=0, pixel forced to 0, col_cnt saturates, frame_err=1.
  - On vid_de falling edge -> HBLANK.
- HBLANK, on entry:
  - col_cnt=0, line_cnt++.
  - If the line just finished was odd (line_cnt[0]==1 before increment), row_base += SRC_W. No multiplier is used.
  - Transitions: vid_de=1 -> LINE; vsync edge -> VBLANK.
- Lines with line_cnt >= 2*SRC_H:
  - bram_en=0, pixel 0, frame_err=1.
- A vsync edge in any state other than WAIT_FRAME goes to VBLANK. This resynchronises a truncated frame without error.

Latency:
- pix_de/pix_hsync/pix_vsync equal vid_* delayed exactly READ_LAT+2 cycles via shift registers.
- pix_data is valid in the same cycle as pix_de.
- A per-pixel "blank" bit travels in a parallel shift register of the same depth.
- pix_data = blank ? 0 : bram_rdata, registered.

Address range:
- Maximum issued address is SRC_W*SRC_H-1 = 76799.
- row_base never exceeds (SRC_H-1)*SRC_W during legal operation.
- Reaching 76800 only after the last legal line is allowed; that address is never issued.

Other rules:
- frame_err clears only on rst.
- No write port, no handshake with the writer. Tearing is accepted.

Decomposition:
- Shared package holds:
  - Frame constants: SRC_W, SRC_H, FRAME_WORDS=76800, DST_W=640, DST_H=480.
  - PIX_W and ADDR_W.
  - State enum: WAIT_FRAME, VBLANK, LINE, HBLANK.
- The writer uses the same package constants.
- One natural sub-module: sync_delay, a parameterised-depth, parameterised-width shift register. It carries {de, hsync, vsync, blank} with depth READ_LAT+2.

Test Plan:
- Reset: hold rst 3 cycles with vid_de toggling -> all outputs 0; no bram_en until after a vsync edge.
- Nominal frame: vsync, then 480 lines of 640 DE cycles, BRAM model returns data=addr[11:0]:
  - Line 0 addresses 0,0,1,1,...,319,319.
  - Line 1 repeats line 0.
  - Line 2 starts at 320.
  - Line 479 ends at 76799.
  - frame_err=0.
- Latency: READ_LAT=1 and READ_LAT=2 builds -> first pix_de is exactly 3 and 4 cycles after the first vid_de, with pix_data=0x000 then 0x000, 0x001 (addr 0,0,1).
- Overlong line of 650 DE cycles -> pixels 640..649 output 0, bram_en=0 for those cycles, frame_err=1 and stays 1.
- Truncated frame: vsync edge after line 100 -> next line restarts at address 0, frame_err unchanged.
- Mid-line reset at col 200 of line 5: rst then vid_de continues -> no bram_en until the next vsync edge; pix_data=0 throughout.
